key_event_encoder: RTL and testbench

//  Debounced, clocked key-to-ASCII encoder for N_KEYS discrete key inputs.

---
 rtl/key_event_encoder.sv | 220 ++++++++++++++++++++++
 tb/tb_key_event_encoder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_encoder.sv
// key_event_encoder: synchronised, debounced key-to-ASCII encoder feeding a show-ahead event FIFO.
// Optional feature macro KEY_REPEAT_EN adds auto-repeat while a single key stays held.
module key_event_encoder #(
    parameter int         N_KEYS          = 4,
    parameter logic [7:0] BASE_CHAR       = 8'h41,
    parameter int         DEBOUNCE_CYCLES = 4,
    parameter int         FIFO_DEPTH      = 4,
    parameter int         REPEAT_DELAY    = 16,
    parameter int         REPEAT_PERIOD   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_KEYS-1:0]             keys_i,
    output logic [7:0]                    ascii_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          overflow_o
);

    localparam int IW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam bit DEB_ONE = (DEBOUNCE_CYCLES == 1);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);

    generate
        if (N_KEYS < 1 || N_KEYS > 32 || DEBOUNCE_CYCLES < 1 || FIFO_DEPTH < 2 ||
            (1 << PW) != FIFO_DEPTH || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
            $error("key_event_encoder: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

    logic [N_KEYS-1:0] sync1_reg, sync2_reg;
    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [IW-1:0]     idx_reg, idx_next;
    logic [IW-1:0]     enc;
    logic [IW-1:0]     push_idx;
    logic              s_zero, s_single, s_match, cnt_done;
    logic              push;
    logic [7:0]        push_code;

`ifdef KEY_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    logic [RW-1:0] rep_cnt_reg, rep_cnt_next;
    logic          rep_first_reg, rep_first_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= keys_i;
            sync2_reg <= sync1_reg;
        end
    end

    assign s_zero   = (sync2_reg == '0);
    assign s_single = !s_zero && ((sync2_reg & (sync2_reg - 1'b1)) == '0);
    assign s_match  = (sync2_reg == (N_KEYS'(1) << idx_reg));
    assign cnt_done = ((32'(cnt_reg) + 32'd1) == 32'(DEBOUNCE_CYCLES));

    // Only consulted when exactly one key is set, so a plain priority scan suffices.
    always_comb begin
        enc = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (sync2_reg[i]) enc = IW'(i);
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        push       = 1'b0;
        push_idx   = idx_reg;
`ifdef KEY_REPEAT_EN
        rep_cnt_next   = rep_cnt_reg;
        rep_first_next = rep_first_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (s_single) begin
                    idx_next = enc;
                    push_idx = enc;
                    if (DEB_ONE) begin
                        push       = 1'b1;
                        state_next = HELD;
                    end else begin
                        cnt_next   = CW'(1);
                        state_next = DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                if (s_match) begin
                    if (cnt_done) begin
                        push       = 1'b1;
                        state_next = HELD;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            HELD: begin
                if (s_zero) begin
                    if (DEB_ONE) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next   = CW'(1);
                        state_next = RELEASE;
                    end
                end
`ifdef KEY_REPEAT_EN
                // Timer only advances on the lone held key; extra keys freeze it.
                else if (s_match) begin
                    if ((32'(rep_cnt_reg) + 32'd1) ==
                        (rep_first_reg ? 32'(REPEAT_DELAY) : 32'(REPEAT_PERIOD))) begin
                        push           = 1'b1;
                        rep_cnt_next   = '0;
                        rep_first_next = 1'b0;
                    end else begin
                        rep_cnt_next = rep_cnt_reg + 1'b1;
                    end
                end
`endif
            end
            RELEASE: begin
                if (s_zero) begin
                    if (cnt_done) state_next = IDLE;
                    else          cnt_next   = cnt_reg + 1'b1;
                end else begin
                    state_next = HELD;
                end
            end
            default: state_next = IDLE;
        endcase
`ifdef KEY_REPEAT_EN
        if (state_next == HELD && state_reg != HELD) begin
            rep_cnt_next   = '0;
            rep_first_next = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
`ifdef KEY_REPEAT_EN
            rep_cnt_reg   <= '0;
            rep_first_reg <= 1'b1;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
`ifdef KEY_REPEAT_EN
            rep_cnt_reg   <= rep_cnt_next;
            rep_first_reg <= rep_first_next;
`endif
        end
    end

    assign push_code = BASE_CHAR + 8'(push_idx);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [7:0]    head_reg;
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, rd_addr;
    logic [PW:0]   count_reg, count_next;
    logic          valid_reg, overflow_reg;
    logic          full, pop, wr_en;

    assign full    = (count_reg == FULL_COUNT);
    assign pop     = valid_reg && ready_i;
    assign wr_en   = push && (!full || pop);
    // Output register looks one entry ahead when the current head is being taken.
    assign rd_addr = rd_ptr_reg + PW'(pop);

    always_comb begin
        count_next = count_reg;
        if (wr_en && !pop)      count_next = count_reg + 1'b1;
        else if (!wr_en && pop) count_next = count_reg - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_reg + PW'(wr_en);
            rd_ptr_reg   <= rd_addr;
            count_reg    <= count_next;
            valid_reg    <= (count_reg != {{PW{1'b0}}, pop});
            overflow_reg <= push && full && !pop;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_reg] <= push_code;
        head_reg <= mem[rd_addr];
    end

    assign ascii_o    = valid_reg ? head_reg : 8'h00;
    assign valid_o    = valid_reg;
    assign count_o    = count_reg;
    assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_key_event_encoder.sv
// Testbench for key_event_encoder: table vectors, hand-written corner sequences and a randomized
// key stream checked against a window-scanning reference model.
module tb_key_event_encoder;

    localparam int D = 4;
`ifdef KEY_REPEAT_EN
    localparam int REP_EVENTS = 4;
`else
    localparam int REP_EVENTS = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] keys_i;
    logic [7:0] ascii_o;
    logic       valid_o;
    logic       ready_i;
    logic [2:0] count_o;
    logic       overflow_o;

    key_event_encoder #(
        .N_KEYS(4), .BASE_CHAR(8'h41), .DEBOUNCE_CYCLES(D), .FIFO_DEPTH(4),
        .REPEAT_DELAY(16), .REPEAT_PERIOD(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .keys_i(keys_i), .ascii_o(ascii_o), .valid_o(valid_o),
        .ready_i(ready_i), .count_o(count_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ovf_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [3:0] seq[$];

    typedef struct {
        logic [3:0] keys;
        int         hold;
        int         n_ev;
        logic [7:0] ch;
    } vec_t;
    vec_t vecs[8];

    logic [7:0] drain_exp[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: one line per accepted event, plus the ascii-is-zero-when-idle rule every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_o && ready_i) begin
                got_q.push_back(ascii_o);
                $display("event ascii=%02h count=%0d t=%0t", ascii_o, count_o, $time);
            end
            if (overflow_o) ovf_cnt++;
            if (!valid_o) check("ascii_zero_when_idle", 32'(ascii_o), 32'h0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [3:0] k, input int n);
        keys_i = k;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        keys_i = 4'b0000;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [7:0] char_of(input logic [3:0] v);
        logic [7:0] c = 8'h41;
        for (int k = 0; k < 4; k++) if (v[k]) c = 8'h41 + 8'(k);
        return c;
    endfunction

    // Reference: scan the synchronised sample stream window by window. A press needs D equal
    // single-key samples while free; a release needs D consecutive zero samples. Any sample that
    // breaks a window is consumed by the break.
    task automatic build_expected();
        int t = 0;
        int j;
        int n = seq.size();
        bit locked = 1'b0;
        exp_q.delete();
        while (t < n) begin
            if (!locked) begin
                if (seq[t] != 0 && $countones(seq[t]) == 1) begin
                    j = 1;
                    while (j < D && t + j < n && seq[t+j] == seq[t]) j++;
                    if (j == D) begin
                        exp_q.push_back(char_of(seq[t]));
                        locked = 1'b1;
                        t += D;
                    end else begin
                        t = t + j + 1;
                    end
                end else begin
                    t++;
                end
            end else begin
                if (seq[t] == 0) begin
                    j = 1;
                    while (j < D && t + j < n && seq[t+j] == 0) j++;
                    if (j == D) begin
                        locked = 1'b0;
                        t += D;
                    end else begin
                        t = t + j + 1;
                    end
                end else begin
                    t++;
                end
            end
        end
    endtask

    initial begin
        int edges;
        clk = 1'b0;
        rst_n = 1'b0;
        keys_i = 4'b0000;
        ready_i = 1'b1;

        vecs[0] = '{4'b0001, 15, 1, 8'h41};
        vecs[1] = '{4'b1000, 15, 1, 8'h44};
        vecs[2] = '{4'b0011, 15, 0, 8'h00};
        vecs[3] = '{4'b0100, 3,  0, 8'h00};
        vecs[4] = '{4'b0100, 4,  1, 8'h43};
        vecs[5] = '{4'b0010, 6,  1, 8'h42};
        vecs[6] = '{4'b0000, 10, 0, 8'h00};
        vecs[7] = '{4'b1111, 10, 0, 8'h00};
        drain_exp = '{8'h41, 8'h42, 8'h43, 8'h44};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_count", 32'(count_o), 0);
        check("rst_ascii", 32'(ascii_o), 0);
        check("rst_overflow", 32'(overflow_o), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven presses
        for (int v = 0; v < 8; v++) begin
            got_q.delete();
            drive(vecs[v].keys, vecs[v].hold);
            drive(4'b0000, 14);
            check($sformatf("vec%0d_events", v), 32'(got_q.size()), 32'(vecs[v].n_ev));
            if (vecs[v].n_ev == 1 && got_q.size() > 0)
                check($sformatf("vec%0d_char", v), 32'(got_q[0]), 32'(vecs[v].ch));
            check($sformatf("vec%0d_count", v), 32'(count_o), 0);
        end

        // Press latency: valid_o rises D+3 edges after the first sampling edge
        do_reset();
        got_q.delete();
        keys_i = 4'b0001;
        edges = 0;
        while (edges < 30) begin
            @(posedge clk);
            edges++;
            #1;
            if (valid_o) break;
        end
        check("latency_edges", 32'(edges), 32'(D + 3));
        check("latency_ascii", 32'(ascii_o), 32'h41);
        @(negedge clk);
        drive(4'b0001, 6);
        drive(4'b0000, 14);
        check("latency_single_event", 32'(got_q.size()), 1);

        // Bounce on key 3, then settle
        got_q.delete();
        for (int i = 0; i < 5; i++) begin
            drive(4'b1000, 2);
            drive(4'b0000, 2);
        end
        check("bounce_no_event", 32'(got_q.size()), 0);
        drive(4'b1000, 10);
        drive(4'b0000, 12);
        check("bounce_events", 32'(got_q.size()), 1);
        if (got_q.size() > 0) check("bounce_char", 32'(got_q[0]), 32'h44);

        // Fill with consumer stalled, overflow on the fifth press, then drain in order
        do_reset();
        ready_i = 1'b0;
        got_q.delete();
        ovf_cnt = 0;
        foreach (drain_exp[i]) begin
            drive(4'b0001 << i, 6);
            drive(4'b0000, 8);
        end
        check("full_no_overflow_yet", 32'(ovf_cnt), 0);
        drive(4'b0001, 6);
        drive(4'b0000, 8);
        check("full_count", 32'(count_o), 4);
        check("full_overflow_pulses", 32'(ovf_cnt), 1);
        check("full_valid", 32'(valid_o), 1);
        check("full_head_stable", 32'(ascii_o), 32'h41);
        ready_i = 1'b1;
        drive(4'b0000, 10);
        check("drain_events", 32'(got_q.size()), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            check($sformatf("drain_char%0d", i), 32'(got_q[i]), 32'(drain_exp[i]));
        check("drain_count", 32'(count_o), 0);

        // Asynchronous reset with two events queued
        do_reset();
        ready_i = 1'b0;
        drive(4'b0001, 6);
        drive(4'b0000, 8);
        drive(4'b0010, 6);
        drive(4'b0000, 8);
        check("prereset_count", 32'(count_o), 2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(valid_o), 0);
        check("async_rst_count", 32'(count_o), 0);
        check("async_rst_ascii", 32'(ascii_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ready_i = 1'b1;
        @(negedge clk);

        // Long hold of key 1: one event, or initial plus three repeats when auto-repeat is built in
        got_q.delete();
        drive(4'b0010, 40);
        drive(4'b0000, 12);
        check("hold_events", 32'(got_q.size()), 32'(REP_EVENTS));
        for (int i = 0; i < got_q.size(); i++)
            check($sformatf("hold_char%0d", i), 32'(got_q[i]), 32'h42);

`ifndef KEY_REPEAT_EN
        // Randomized key stream against the reference model
        seq.delete();
        while (seq.size() < 700) begin
            int r;
            int h;
            logic [3:0] p;
            r = $urandom_range(0, 9);
            h = $urandom_range(1, 12);
            if (r < 6)      p = 4'b0001 << $urandom_range(0, 3);
            else if (r < 8) p = 4'b0000;
            else            p = 4'($urandom_range(0, 15));
            repeat (h) seq.push_back(p);
        end
        repeat (30) seq.push_back(4'b0000);
        build_expected();
        do_reset();
        got_q.delete();
        ovf_cnt = 0;
        foreach (seq[i]) drive(seq[i], 1);
        drive(4'b0000, 10);
        check("rand_events", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("rand_char%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        check("rand_overflow", 32'(ovf_cnt), 0);
        check("rand_count", 32'(count_o), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
